// File: rtl/psram_qpi_ctrl.sv
// Purpose: sequences QPI PSRAM transactions (0xEB quad read / 0x38 quad write) from a valid/ready request port, after switching the device to QPI mode.
// Latency: 2-clock beats, pins lag the sequencer by one clock; word write resp at cycle 33, word read resp at cycle 45 after acceptance.
// Backpressure: req_ready is high only in IDLE after init; one request in flight, the next is accepted after the CE gap.
module psram_qpi_ctrl #(
    parameter logic [7:0] QPI_ENTER_CMD = 8'h35,
    parameter int          WAIT_BEATS    = 6,
    parameter int          CE_GAP_BEATS  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        init_done,
    output logic        sck,
    output logic        ce_n,
    output logic [3:0]  dio_out,
    output logic        dio_oe,
    input  logic [3:0]  dio_in
);

    typedef enum logic [3:0] {
        S_INIT,
        S_INIT_GAP,
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_RDATA,
        S_WDATA,
        S_GAP
    } state_t;

    state_t      state;
    logic [4:0]  beat_cnt;
    logic        phase_b;        // 0 = phase A (sck low), 1 = phase B (sck high)
    logic        wr_q;
    logic [23:0] addr_q;
    logic [4:0]  data_beats_q;   // 2, 4 or 8 nibble beats
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic [4:0]  beats;
    logic        beat_last;
    logic [3:0]  cur_nib;
    logic [4:0]  data_idx;

    // Beat length of the current state and end-of-state detection.
    always_comb begin
        beats = 5'd1;
        case (state)
            S_INIT:            beats = 5'd8;
            S_INIT_GAP, S_GAP: beats = 5'(CE_GAP_BEATS);
            S_CMD:             beats = 5'd2;
            S_ADDR:            beats = 5'd6;
            S_DUMMY:           beats = 5'(WAIT_BEATS);
            S_RDATA, S_WDATA:  beats = data_beats_q;
            default:           beats = 5'd1;
        endcase
        beat_last = phase_b && (beat_cnt == beats - 5'd1);
    end

    // Data beat b carries byte b/2, high nibble first: bit offset 8*(b/2) + (b even ? 4 : 0).
    assign data_idx = {beat_cnt[2:1], ~beat_cnt[0], 2'b00};

    // Nibble to drive for the current beat.
    always_comb begin
        cur_nib = 4'h0;
        case (state)
            S_INIT:  cur_nib = {3'b000, QPI_ENTER_CMD[3'd7 - beat_cnt[2:0]]};
            S_CMD: begin
                if (wr_q) cur_nib = beat_cnt[0] ? 4'h8 : 4'h3;
                else      cur_nib = beat_cnt[0] ? 4'hB : 4'hE;
            end
            S_ADDR: begin
                case (beat_cnt[2:0])
                    3'd0:    cur_nib = addr_q[23:20];
                    3'd1:    cur_nib = addr_q[19:16];
                    3'd2:    cur_nib = addr_q[15:12];
                    3'd3:    cur_nib = addr_q[11:8];
                    3'd4:    cur_nib = addr_q[7:4];
                    default: cur_nib = addr_q[3:0];
                endcase
            end
            S_WDATA: cur_nib = wdata_q[data_idx +: 4];
            default: cur_nib = 4'h0;
        endcase
    end

    // Sequencer FSM: registered pins follow the state one clock later, read nibbles
    // are captured on the edge where sck rises, and state/handshake advance per beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_INIT;
            beat_cnt     <= 5'd0;
            phase_b      <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= 24'h0;
            data_beats_q <= 5'd2;
            wdata_q      <= 32'h0;
            rdata_q      <= 32'h0;
            init_done    <= 1'b0;
            req_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            sck          <= 1'b0;
            ce_n         <= 1'b1;
            dio_out      <= 4'h0;
            dio_oe       <= 1'b0;
        end else begin
            sck        <= 1'b0;
            ce_n       <= 1'b1;
            dio_out    <= 4'h0;
            dio_oe     <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                S_INIT, S_CMD, S_ADDR, S_WDATA: begin
                    sck     <= phase_b;
                    ce_n    <= 1'b0;
                    dio_out <= cur_nib;
                    dio_oe  <= 1'b1;
                end
                S_DUMMY, S_RDATA: begin
                    sck  <= phase_b;
                    ce_n <= 1'b0;
                end
                S_GAP: begin
                    if (beat_cnt == 5'd0 && !phase_b) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= wr_q ? 32'h0 : rdata_q;
                    end
                end
                default: ;
            endcase

            // Pins are in phase A here, so the device is holding this beat's nibble.
            if (state == S_RDATA && phase_b)
                rdata_q[data_idx +: 4] <= dio_in;

            if (state == S_IDLE) begin
                if (req_valid && req_ready) begin
                    state     <= S_CMD;
                    beat_cnt  <= 5'd0;
                    phase_b   <= 1'b0;
                    req_ready <= 1'b0;
                    wr_q      <= req_write;
                    addr_q    <= req_addr;
                    wdata_q   <= req_wdata;
                    rdata_q   <= 32'h0;
                    case (req_size)
                        2'd0:    data_beats_q <= 5'd2;
                        2'd1:    data_beats_q <= 5'd4;
                        default: data_beats_q <= 5'd8;
                    endcase
                end
            end else begin
                phase_b <= ~phase_b;
                if (phase_b) begin
                    if (beat_last) begin
                        beat_cnt <= 5'd0;
                        case (state)
                            S_INIT:     state <= S_INIT_GAP;
                            S_INIT_GAP: begin
                                state     <= S_IDLE;
                                init_done <= 1'b1;
                                req_ready <= 1'b1;
                            end
                            S_CMD:      state <= S_ADDR;
                            S_ADDR:     state <= wr_q ? S_WDATA : S_DUMMY;
                            S_DUMMY:    state <= S_RDATA;
                            S_RDATA:    state <= S_GAP;
                            S_WDATA:    state <= S_GAP;
                            S_GAP: begin
                                state     <= S_IDLE;
                                req_ready <= 1'b1;
                            end
                            default:    state <= S_IDLE;
                        endcase
                    end else begin
                        beat_cnt <= beat_cnt + 5'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_psram_qpi_ctrl.sv
// Purpose: directed self-checking bench for psram_qpi_ctrl with a small QPI PSRAM read model.
// Latency: checks response cycle numbers against the documented beat counts.
// Backpressure: requests wait on req_ready; back-to-back spacing is measured.
module tb_psram_qpi_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [23:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        init_done;
    logic        sck;
    logic        ce_n;
    logic [3:0]  dio_out;
    logic        dio_oe;
    logic [3:0]  dio_in = 4'h0;

    psram_qpi_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .init_done  (init_done),
        .sck        (sck),
        .ce_n       (ce_n),
        .dio_out    (dio_out),
        .dio_oe     (dio_oe),
        .dio_in     (dio_in)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];   // expected resp_rdata, pushed at acceptance
    logic [3:0]  nib_q[$];   // expected driven nibbles of the current transaction
    logic [31:0] dev_word = 32'h0;

    // Device read model: counts sck rises in a frame and presents read nibble k
    // (byte k/2, high nibble first) from the falling edge before read beat 14+k.
    int rise_cnt = 0;
    always @(posedge sck or posedge ce_n) begin
        if (ce_n) rise_cnt <= 0;
        else      rise_cnt <= rise_cnt + 1;
    end

    always @(negedge sck) begin
        int k;
        int byte_n;
        k = rise_cnt - 14;
        if (k >= 0 && k < 8) begin
            byte_n = k / 2;
            if (k % 2 == 0) dio_in = dev_word[8*byte_n + 4 +: 4];
            else            dio_in = dev_word[8*byte_n +: 4];
        end else begin
            dio_in = 4'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Runs the 18 cycles after reset release and checks the QPI enter frame.
    task automatic init_check(input string tag);
        logic [7:0] bits;
        int nrise, ce_low, early, hi_bad;
        logic prev;
        bits = 8'h0; nrise = 0; ce_low = 0; early = 0; hi_bad = 0;
        prev = sck;
        for (int n = 1; n <= 18; n++) begin
            step();
            if (sck && !prev && !ce_n) begin
                bits = {bits[6:0], dio_out[0]};
                nrise++;
                if (dio_out[3:1] != 3'b000 || !dio_oe) hi_bad++;
            end
            prev = sck;
            if (!ce_n) ce_low++;
            if (n < 18 && (req_ready || init_done)) early++;
        end
        chk({tag, " enter_cmd_bits"}, bits, 32'h35);
        chk({tag, " enter_rises"}, nrise, 8);
        chk({tag, " enter_pins"}, hi_bad, 0);
        chk({tag, " enter_ce_low"}, ce_low, 16);
        chk({tag, " early_ready"}, early, 0);
        chk({tag, " init_done_c18"}, init_done, 1);
        chk({tag, " ready_c18"}, req_ready, 1);
        chk({tag, " ce_n_gap"}, ce_n, 1);
    endtask

    // One request end to end: handshake, pin frame, response timing and data.
    task automatic do_txn(input string tag, input logic wr, input logic [23:0] a,
                          input logic [1:0] sz, input logic [31:0] wd,
                          input logic [31:0] rd, output int acc_cyc);
        int n_bytes, exp_cyc, waited, nrise, ce_low, oe_bad, extra;
        logic got, prev;
        logic [31:0] exp_rd;
        dev_word = rd;
        n_bytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        exp_cyc = wr ? 2*(8 + 2*n_bytes) + 1 : 2*(14 + 2*n_bytes) + 1;
        if (wr)               exp_rd = 32'h0;
        else if (n_bytes == 1) exp_rd = {24'h0, rd[7:0]};
        else if (n_bytes == 2) exp_rd = {16'h0, rd[15:0]};
        else                   exp_rd = rd;

        nib_q.delete();
        nib_q.push_back(wr ? 4'h3 : 4'hE);
        nib_q.push_back(wr ? 4'h8 : 4'hB);
        for (int i = 5; i >= 0; i--) nib_q.push_back(a[4*i +: 4]);
        if (wr) begin
            for (int b = 0; b < n_bytes; b++) begin
                nib_q.push_back(wd[8*b + 4 +: 4]);
                nib_q.push_back(wd[8*b +: 4]);
            end
        end

        waited = 0;
        while (!req_ready && waited < 200) begin
            step();
            waited++;
        end
        chk({tag, " ready_seen"}, req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_size = sz; req_wdata = wd;
        step();
        acc_cyc = cyc;
        exp_q.push_back(exp_rd);
        chk({tag, " ready_drop"}, req_ready, 0);
        // Inputs change after acceptance and must be ignored.
        req_valid = 1'b0; req_write = ~wr; req_addr = ~a; req_size = ~sz; req_wdata = ~wd;

        prev = sck; nrise = 0; ce_low = 0; oe_bad = 0; extra = 0; got = 1'b0;
        for (int n = 1; n <= 120 && !got; n++) begin
            step();
            if (!ce_n) ce_low++;
            if (sck && !prev && !ce_n) begin
                if (nrise < 8 || wr) begin
                    if (!dio_oe) oe_bad++;
                    if (nib_q.size() > 0) chk({tag, " nibble"}, dio_out, nib_q.pop_front());
                    else extra++;
                end else if (dio_oe) begin
                    oe_bad++;
                end
                nrise++;
            end
            prev = sck;
            if (resp_valid) begin
                got = 1'b1;
                chk({tag, " resp_cycle"}, n, exp_cyc);
                if (exp_q.size() > 0) chk({tag, " resp_rdata"}, resp_rdata, exp_q.pop_front());
                else chk({tag, " scoreboard_empty"}, exp_q.size(), 1);
            end
        end
        chk({tag, " resp_seen"}, got, 1);
        if (!got) exp_q.delete();
        chk({tag, " nibbles_left"}, nib_q.size() + extra, 0);
        chk({tag, " ce_low_cycles"}, ce_low, exp_cyc - 1);
        chk({tag, " oe_frame"}, oe_bad, 0);
        step();
        chk({tag, " resp_pulse"}, resp_valid, 0);
        chk({tag, " rdata_hold"}, resp_rdata, exp_rd);
    endtask

    initial begin
        int acc1, acc2, rel, bad;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 24'h0;
        req_size = 2'd0; req_wdata = 32'h0;
        repeat (3) step();
        chk("rst sck", sck, 0);
        chk("rst ce_n", ce_n, 1);
        chk("rst dio_out", dio_out, 0);
        chk("rst dio_oe", dio_oe, 0);
        chk("rst req_ready", req_ready, 0);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst resp_rdata", resp_rdata, 0);
        chk("rst init_done", init_done, 0);

        reset = 1'b0;
        init_check("init");

        do_txn("wr_word", 1'b1, 24'h000100, 2'd2, 32'h12345678, 32'h0, acc1);
        do_txn("wr_word2", 1'b1, 24'h000104, 2'd2, 32'hA1B2C3D4, 32'h0, acc2);
        chk("b2b spacing", acc2 - acc1, 35);
        do_txn("rd_word", 1'b0, 24'h000100, 2'd2, 32'h0, 32'h12345678, acc1);
        do_txn("rd_byte", 1'b0, 24'h000100, 2'd0, 32'h0, 32'h12345678, acc1);
        do_txn("rd_half", 1'b0, 24'hABCDEF, 2'd1, 32'h0, 32'h9ABC5678, acc1);
        do_txn("wr_byte", 1'b1, 24'h0000FF, 2'd0, 32'hDEADBEA5, 32'h0, acc1);
        do_txn("wr_size3", 1'b1, 24'h5A5A5A, 2'd3, 32'h0F1E2D3C, 32'h0, acc1);

        // Abort a write at cycle 10, then hold a request from reset release.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 24'h000300;
        req_size = 2'd2; req_wdata = 32'h11223344;
        step();
        req_valid = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        #1;
        chk("abort ce_n", ce_n, 1);
        chk("abort dio_oe", dio_oe, 0);
        chk("abort sck", sck, 0);
        chk("abort init_done", init_done, 0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (resp_valid || req_ready) bad++;
        end
        chk("abort no_resp", bad, 0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 24'h000200;
        req_size = 2'd2; req_wdata = 32'hCAFEF00D;
        reset = 1'b0;
        rel = cyc;
        init_check("reinit");
        do_txn("early_wr", 1'b1, 24'h000200, 2'd2, 32'hCAFEF00D, 32'h0, acc1);
        chk("early accept_cycle", acc1 - rel, 19);
        do_txn("post_rd", 1'b0, 24'h000200, 2'd2, 32'h0, 32'hCAFEF00D, acc1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psram_qpi_ctrl.md
# psram_qpi_ctrl

Master-side sequencer for the QPI PSRAM device pins (sck, ce_n, 4-bit dio). It sits between a simple valid/ready memory request port, fed by the APB/AXI bridge, and the PSRAM pads. After reset it switches the device into QPI mode. It then converts each request into a framed QPI transaction: 0xEB fast-quad-read or 0x38 quad-write, with 24-bit address, dummy beats and nibble data. Tri-state resolution of dio is done outside the block.

## Interface
- QPI_ENTER_CMD, 8'h35: command sent once after reset, in SPI mode.
- WAIT_BEATS, 6: dummy beats between address and read data.
- CE_GAP_BEATS, 1: minimum beats ce_n stays high between transactions.
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  24  byte address, passed unmodified.
- req_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is treated as 2.
- req_wdata  in  32  write data, byte0 in [7:0].
- resp_valid  out  1  one-cycle completion pulse for both reads and writes.
- resp_rdata  out  32  read data; unread bytes are zero; 0 for writes.
- init_done  out  1  high once the QPI enter sequence has completed.
- sck  out  1  PSRAM clock.
- ce_n  out  1  PSRAM chip enable, active low.
- dio_out  out  4  data driven toward the pads.
- dio_oe  out  1  pad output enable.
- dio_in  in  4  data sampled from the pads.

## Operation
- **Beat:** 2 clocks. Phase A has sck=0; dio_out/dio_oe change only at phase A entry. Phase B has sck=1; the device samples on the sck rise.
- **States:** INIT → INIT_GAP → IDLE → CMD → ADDR → (read: DUMMY → RDATA | write: WDATA) → GAP → IDLE.
- **INIT:** ce_n low; 8 beats of QPI_ENTER_CMD in SPI form, MSB first, on dio_out[0]; dio_out[3:1]=0; dio_oe=1.
- **INIT_GAP:** CE_GAP_BEATS beats with ce_n high; then init_done=1.
- **IDLE:** req_ready=1 only here, and only when init_done=1. Requests presented during INIT wait; nothing is dropped.
- **Capture on accept:** write, addr, size and wdata are latched on acceptance; the request inputs are ignored afterwards.
- **CMD:** 2 beats, command nibbles high then low: 0xE,0xB for read; 0x3,0x8 for write.
- **ADDR:** 6 beats, addr[23:20] first down to addr[3:0].
- **WDATA:** 2·N beats, where N = bytes (1/2/4). Order: byte0 high nibble, byte0 low nibble, byte1 high, …
- **DUMMY:** WAIT_BEATS beats; dio_oe=0 from the first DUMMY beat until ce_n rises.
- **RDATA:** 2·N beats. dio_in is captured on the clock edge where sck goes 0→1, with the same nibble order as writes. It is assembled into resp_rdata bytes 0..N-1; the remaining bytes are 0.
- **GAP:** ce_n=1, sck=0, dio_oe=0 for CE_GAP_BEATS beats. resp_valid pulses on the first GAP cycle; resp_rdata is stable from that cycle until the next resp_valid.
- **Beat counter:** 5 bits, reset at each state entry; a state transition occurs after the phase B clock of its last beat.
- **Reset mid-transaction:** all outputs return to reset values immediately (async). No resp_valid is issued for the aborted request. INIT is re-run.

## Timing
- **Reset values:** sck=0, ce_n=1, dio_out=0, dio_oe=0, req_ready=0, resp_valid=0, resp_rdata=0, init_done=0.
- **Cycle 0:** the acceptance edge; req_ready drops at this edge. ce_n falls at cycle 1; the first phase A is cycle 1.
- **Word write:** 16 beats; ce_n low for cycles 1–32; resp_valid at cycle 33.
- **Byte write:** 10 beats; resp_valid at cycle 21.
- **Word read (WAIT_BEATS=6):** 22 beats; resp_valid at cycle 45.
- **Byte read:** resp_valid at cycle 33.
- **Back-to-back requests:** req_ready returns after CE_GAP_BEATS·2 cycles following resp_valid. Minimum spacing between acceptances of consecutive word writes is 35 cycles with defaults.
- **Init:** completes 18 cycles after reset release, with init_done rising at cycle 18.

## Test plan
- **Reset release:** dio_out[0] shifts 0,0,1,1,0,1,0,1 over 8 sck rises with ce_n low; ce_n then high for 1 beat; init_done=1 at cycle 18; req_ready=1 afterwards.
- **Word write:** addr 0x000100, wdata 0x12345678, size 2 → nibbles at sck rises are 3,8,0,0,0,1,0,0,7,8,5,6,3,4,1,2; ce_n low for 32 cycles; resp_valid at cycle 33; resp_rdata=0.
- **Word read:** addr 0x000100, device model returns 0x12345678 → dio_oe=0 from beat 8; resp_rdata=0x12345678 at cycle 45.
- **Byte read:** same addr, size 0 → 2 data beats; resp_rdata=0x00000078 at cycle 33.
- **Early request:** req_valid held high from reset release → not accepted before init_done; accepted on the first IDLE cycle; completes normally.
- **Reset mid-write:** reset asserted at cycle 10 → ce_n=1, dio_oe=0, sck=0 immediately; no resp_valid; INIT replays; next request completes with correct data.
